combo_engine: RTL and testbench
===============================

COMBO_ENGINE -- requirements
Module: combo_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of independent player channels.
REQ-002 SHALL have parameter W, default 7: combo counter width per channel.
REQ-003 SHALL have parameter FULL_BONUS, default 2: combo increment for a full-clear hit.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 0: idle cycles before combo decays to 0; 0 disables timeout.
REQ-005 SHALL have parameters TIER1/TIER2/TIER3, defaults 5/10/20: multiplier tier thresholds.
REQ-006 SHALL have port clk, input, 1: system clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port miss, input, NUM_CH: per-channel miss level, bit i is channel i.
REQ-009 SHALL have port non_full_clear_hit, input, NUM_CH: per-channel ordinary hit level.
REQ-010 SHALL have port full_clear_hit, input, NUM_CH: per-channel full-clear hit level.
REQ-011 SHALL have port combo_val, output, NUM_CH*W: current combo; channel i in bits [i*W +: W].
REQ-012 SHALL have port max_combo, output, NUM_CH*W: highest combo_val reached since reset, per channel.
REQ-013 SHALL have port tier, output, NUM_CH*2: multiplier tier 0..3 (x1..x4), per channel.
REQ-014 SHALL have port combo_break, output, NUM_CH: one-cycle pulse when a nonzero combo is cleared.

Function
REQ-015 SHALL treat every input as a level and act only on its rising edge: input high at edge k, registered copy low from edge k-1.
REQ-016 SHALL apply a detected event at edge k, visible on outputs after edge k (1-cycle latency); a held input SHALL count once.
REQ-017 Event priority per channel SHALL be miss > full_clear_hit > non_full_clear_hit; only the highest detected event applies.
REQ-018 A miss edge SHALL set combo_val to 0.
REQ-019 A full-clear edge SHALL add FULL_BONUS; a non-full edge SHALL add 1.
REQ-020 Additions SHALL saturate at 2^W-1, with no wrap-around.
REQ-021 With TIMEOUT_CYCLES>0, a per-channel idle counter SHALL reset on any hit edge and increment otherwise; on reaching TIMEOUT_CYCLES it SHALL set combo_val to 0 and restart the count.
REQ-022 combo_break[i] SHALL pulse for exactly one cycle, coincident with the update, when a miss or timeout clears a nonzero combo_val; clearing a zero combo SHALL NOT pulse.
REQ-023 max_combo SHALL update in the same cycle as combo_val whenever the new combo_val exceeds it.
REQ-024 tier SHALL be combinational from registered combo_val: 0 if <TIER1, 1 if <TIER2, 2 if <TIER3, else 3.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels SHALL all apply in the same cycle.

Reset
REQ-026 While reset is high at a clock edge, combo_val, max_combo, idle counters, edge registers and combo_break SHALL be set to 0; tier therefore reads 0.
REQ-027 Reset SHALL override any event in the same cycle, including mid-timeout.
REQ-028 An input held high through reset deassertion SHALL NOT produce an event until it falls and rises again.

Structure
REQ-029 Tier encoding constants and default thresholds SHALL reside in the shared package combo_pkg.
REQ-030 Per-channel logic SHALL be one sub-module, combo_channel, instantiated NUM_CH times by generate; combo_engine SHALL contain only the instantiation and bus packing.

Verification
REQ-031 Default parameters, two non-full pulses then two full-clear pulses -> combo_val 1, 2, 4, 6; tier 1 after 6; max_combo 6.
REQ-032 Miss and full_clear_hit rise together with combo 6 -> combo_val 0, combo_break one cycle, max_combo stays 6.
REQ-033 full_clear_hit held high 3 cycles -> combo_val increases by 2 once only.
REQ-034 W=3, eight non-full pulses -> combo_val saturates at 7, never 0.
REQ-035 TIMEOUT_CYCLES=10, combo 3 then idle -> combo_val 0 with combo_break exactly 10 cycles after the last hit edge.
REQ-036 NUM_CH=2, ch0 hit and ch1 miss in the same cycle with ch1 at 4 -> ch0 1, ch1 0; then reset with non-full held through release -> all outputs 0 and no increment until a new rising edge.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared definitions for the combo scoring engine: multiplier tier encoding,
// default tier thresholds and the tier lookup helper.
package combo_pkg;

    typedef enum logic [1:0] {
        TIER_X1 = 2'd0,
        TIER_X2 = 2'd1,
        TIER_X3 = 2'd2,
        TIER_X4 = 2'd3
    } tier_e;

    localparam int unsigned DEF_TIER1 = 5;
    localparam int unsigned DEF_TIER2 = 10;
    localparam int unsigned DEF_TIER3 = 20;

    function automatic tier_e tier_of(input int unsigned value,
                                      input int unsigned t1,
                                      input int unsigned t2,
                                      input int unsigned t3);
        if (value < t1)      return TIER_X1;
        else if (value < t2) return TIER_X2;
        else if (value < t3) return TIER_X3;
        else                 return TIER_X4;
    endfunction

endpackage

// File: rtl/combo_channel.sv
// One player channel: edge detection, saturating combo counter, idle timeout,
// high-water mark and multiplier tier.
module combo_channel
    import combo_pkg::*;
#(
    parameter int unsigned W              = 7,
    parameter int unsigned FULL_BONUS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIER1          = DEF_TIER1,
    parameter int unsigned TIER2          = DEF_TIER2,
    parameter int unsigned TIER3          = DEF_TIER3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         miss,
    input  logic         non_full_clear_hit,
    input  logic         full_clear_hit,
    output logic [W-1:0] combo_val,
    output logic [W-1:0] max_combo,
    output logic [1:0]   tier,
    output logic         combo_break
);

    localparam int unsigned MAXV  = (1 << W) - 1;
    localparam int unsigned BONUS = (FULL_BONUS > MAXV) ? MAXV : FULL_BONUS;
    localparam int unsigned IW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [W:0]    INC_FULL  = (W + 1)'(BONUS);
    localparam logic [W:0]    INC_ONE   = (W + 1)'(1);

    // Bit order in the level vectors: {miss, full_clear_hit, non_full_clear_hit}
    logic [2:0]    lvl, lvl_q, hold_q, rise;
    logic [IW-1:0] idle_q, idle_d;
    logic [W-1:0]  combo_d, max_d;
    logic [W:0]    sum;
    logic          break_d, hit_rise, timeout;

    assign lvl = {miss, full_clear_hit, non_full_clear_hit};

    always_comb begin
        // hold_q masks inputs that were high through reset until they are seen low
        rise     = lvl & ~lvl_q & ~hold_q;
        hit_rise = rise[1] | rise[0];
        timeout  = 1'b0;
        idle_d   = idle_q;
        if (TIMEOUT_CYCLES != 0) begin
            if (hit_rise) begin
                idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
                idle_d  = '0;
                timeout = 1'b1;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end

        sum     = {1'b0, combo_val} + (rise[1] ? INC_FULL : INC_ONE);
        combo_d = combo_val;
        break_d = 1'b0;
        if (rise[2] || timeout) begin
            combo_d = '0;
            break_d = |combo_val;
        end else if (hit_rise) begin
            combo_d = sum[W] ? '1 : sum[W-1:0];
        end
        max_d = (combo_d > max_combo) ? combo_d : max_combo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q       <= '0;
            hold_q      <= '1;
            idle_q      <= '0;
            combo_val   <= '0;
            max_combo   <= '0;
            combo_break <= 1'b0;
        end else begin
            lvl_q       <= lvl;
            hold_q      <= hold_q & lvl;
            idle_q      <= idle_d;
            combo_val   <= combo_d;
            max_combo   <= max_d;
            combo_break <= break_d;
        end
    end

    assign tier = tier_of(32'(combo_val), TIER1, TIER2, TIER3);

endmodule

// File: rtl/combo_engine.sv
// Multi-channel combo engine: one combo_channel per player, packed onto
// flat output buses with channel i in the i-th slice.
module combo_engine
    import combo_pkg::*;
#(
    parameter int unsigned NUM_CH         = 1,
    parameter int unsigned W              = 7,
    parameter int unsigned FULL_BONUS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIER1          = DEF_TIER1,
    parameter int unsigned TIER2          = DEF_TIER2,
    parameter int unsigned TIER3          = DEF_TIER3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   miss,
    input  logic [NUM_CH-1:0]   non_full_clear_hit,
    input  logic [NUM_CH-1:0]   full_clear_hit,
    output logic [NUM_CH*W-1:0] combo_val,
    output logic [NUM_CH*W-1:0] max_combo,
    output logic [NUM_CH*2-1:0] tier,
    output logic [NUM_CH-1:0]   combo_break
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        combo_channel #(
            .W              (W),
            .FULL_BONUS     (FULL_BONUS),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .TIER1          (TIER1),
            .TIER2          (TIER2),
            .TIER3          (TIER3)
        ) u_ch (
            .clk                (clk),
            .reset              (reset),
            .miss               (miss[i]),
            .non_full_clear_hit (non_full_clear_hit[i]),
            .full_clear_hit     (full_clear_hit[i]),
            .combo_val          (combo_val[i*W +: W]),
            .max_combo          (max_combo[i*W +: W]),
            .tier               (tier[i*2 +: 2]),
            .combo_break        (combo_break[i])
        );
    end

endmodule

// File: tb/tb_combo_engine.sv
// Bench for combo_engine: a default single-channel instance and a two-channel,
// 3-bit, timeout-10 instance, both tracked by a behavioural score model.
module tb_combo_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [0:0] m0, fc0, nf0, b0;
    logic [6:0] cv0, mx0;
    logic [1:0] t0;
    logic [1:0] m1, fc1, nf1, b1;
    logic [5:0] cv1, mx1;
    logic [3:0] t1;

    combo_engine u_dut0 (
        .clk(clk), .reset(rst), .miss(m0), .non_full_clear_hit(nf0),
        .full_clear_hit(fc0), .combo_val(cv0), .max_combo(mx0),
        .tier(t0), .combo_break(b0)
    );

    combo_engine #(.NUM_CH(2), .W(3), .TIMEOUT_CYCLES(10)) u_dut1 (
        .clk(clk), .reset(rst), .miss(m1), .non_full_clear_hit(nf1),
        .full_clear_hit(fc1), .combo_val(cv1), .max_combo(mx1),
        .tier(t1), .combo_break(b1)
    );

    int passed = 0;
    int total  = 0;

    // Score model, index 0 = dut0 ch0, 1/2 = dut1 ch0/ch1
    int r_w[3]  = '{7, 3, 3};
    int r_to[3] = '{0, 10, 10};
    int r_combo[3], r_max[3], r_idle[3], r_brk[3];
    bit r_lm[3], r_lf[3], r_ln[3];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_tier(int v);
        if (v < 5)  return 0;
        if (v < 10) return 1;
        if (v < 20) return 2;
        return 3;
    endfunction

    task automatic model_channel(int id, bit mi, bit fc, bit nf);
        bit rm, rf, rn, tmo;
        int cap;
        if (rst === 1'b1) begin
            r_combo[id] = 0; r_max[id] = 0; r_idle[id] = 0; r_brk[id] = 0;
            // an input must be seen low after reset before it can count
            r_lm[id] = 1; r_lf[id] = 1; r_ln[id] = 1;
            return;
        end
        rm = mi && !r_lm[id];
        rf = fc && !r_lf[id];
        rn = nf && !r_ln[id];
        r_lm[id] = mi; r_lf[id] = fc; r_ln[id] = nf;
        tmo = 0;
        if (r_to[id] > 0) begin
            if (rf || rn) r_idle[id] = 0;
            else begin
                r_idle[id]++;
                if (r_idle[id] == r_to[id]) begin
                    r_idle[id] = 0;
                    tmo = 1;
                end
            end
        end
        cap = (1 << r_w[id]) - 1;
        r_brk[id] = 0;
        if (rm || tmo) begin
            r_brk[id] = (r_combo[id] != 0) ? 1 : 0;
            r_combo[id] = 0;
        end else if (rf) begin
            r_combo[id] = (r_combo[id] + 2 > cap) ? cap : r_combo[id] + 2;
        end else if (rn) begin
            r_combo[id] = (r_combo[id] + 1 > cap) ? cap : r_combo[id] + 1;
        end
        if (r_combo[id] > r_max[id]) r_max[id] = r_combo[id];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_channel(0, m0[0], fc0[0], nf0[0]);
        model_channel(1, m1[0], fc1[0], nf1[0]);
        model_channel(2, m1[1], fc1[1], nf1[1]);
        check("combo_d0", 32'(cv0), r_combo[0]);
        check("max_d0",   32'(mx0), r_max[0]);
        check("tier_d0",  32'(t0),  exp_tier(r_combo[0]));
        check("brk_d0",   32'(b0),  r_brk[0]);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("combo_d1_%0d", c), 32'(cv1[c*3 +: 3]), r_combo[c+1]);
            check($sformatf("max_d1_%0d", c),   32'(mx1[c*3 +: 3]), r_max[c+1]);
            check($sformatf("tier_d1_%0d", c),  32'(t1[c*2 +: 2]),  exp_tier(r_combo[c+1]));
            check($sformatf("brk_d1_%0d", c),   32'(b1[c]),         r_brk[c+1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0 = '0; fc0 = '0; nf0 = '0;
        m1 = '0; fc1 = '0; nf1 = '0;
        step(); step();
        check("rst_combo0", 32'(cv0), 0);
        check("rst_max1",   32'(mx1), 0);
        check("rst_tier0",  32'(t0),  0);
        check("rst_brk1",   32'(b1),  0);
        rst = 1'b0;
        step();

        // two ordinary hits then two full clears
        nf0 = 1'b1; step(); check("seq_1", 32'(cv0), 1); nf0 = 1'b0; step();
        nf0 = 1'b1; step(); check("seq_2", 32'(cv0), 2); nf0 = 1'b0; step();
        fc0 = 1'b1; step(); check("seq_4", 32'(cv0), 4); check("seq_tier4", 32'(t0), 0);
        fc0 = 1'b0; step();
        fc0 = 1'b1; step(); check("seq_6", 32'(cv0), 6); check("seq_tier6", 32'(t0), 1);
        check("seq_max6", 32'(mx0), 6);
        fc0 = 1'b0; step();

        // miss beats full clear in the same cycle
        m0 = 1'b1; fc0 = 1'b1; step();
        check("miss_combo", 32'(cv0), 0);
        check("miss_brk",   32'(b0),  1);
        check("miss_max",   32'(mx0), 6);
        m0 = 1'b0; fc0 = 1'b0; step();
        check("miss_brk_end", 32'(b0), 0);

        // held full clear counts once
        fc0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); check("held_fc", 32'(cv0), 2);
        end
        fc0 = 1'b0; step();

        // saturation at 7 on the 3-bit instance
        for (int k = 1; k <= 8; k++) begin
            nf1[0] = 1'b1; step();
            check("sat", 32'(cv1[2:0]), (k < 7) ? k : 7);
            nf1[0] = 1'b0; step();
        end

        // timeout: combo 3 then idle for exactly 10 cycles
        for (int k = 0; k < 3; k++) begin
            nf1[1] = 1'b1; step(); nf1[1] = 1'b0;
            if (k < 2) step();
        end
        check("to_pre", 32'(cv1[5:3]), 3);
        for (int j = 1; j <= 10; j++) begin
            step();
            check($sformatf("to_combo_%0d", j), 32'(cv1[5:3]), (j < 10) ? 3 : 0);
            check($sformatf("to_brk_%0d", j),   32'(b1[1]),    (j < 10) ? 0 : 1);
        end

        // independent channels in the same cycle
        m1[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nf1[1] = 1'b1; step(); nf1[1] = 1'b0; m1[0] = 1'b0; step();
        end
        check("ind_pre_ch1", 32'(cv1[5:3]), 4);
        nf1[0] = 1'b1; m1[1] = 1'b1; step();
        check("ind_ch0",  32'(cv1[2:0]), 1);
        check("ind_ch1",  32'(cv1[5:3]), 0);
        check("ind_brk",  32'(b1),       2);
        nf1[0] = 1'b0; m1[1] = 1'b0; step();

        // reset with hits held through release
        nf0 = 1'b1; nf1 = 2'b11; rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        check("hold_cv0",  32'(cv0), 0);
        check("hold_cv1",  32'(cv1), 0);
        check("hold_mx1",  32'(mx1), 0);
        check("hold_t1",   32'(t1),  0);
        check("hold_brk1", 32'(b1),  0);
        nf0 = 1'b0; nf1 = 2'b00; step();
        check("hold_low", 32'(cv1), 0);
        nf0 = 1'b1; nf1 = 2'b11; step();
        check("hold_rise0", 32'(cv0), 1);
        check("hold_rise1", 32'(cv1), 32'h09);
        nf0 = 1'b0; nf1 = 2'b00; step();

        // randomized traffic with quiet stretches and occasional resets
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (((i / 25) % 3) == 2) begin
                m0 = '0; fc0 = '0; nf0 = '0; m1 = '0; fc1 = '0; nf1 = '0;
            end else begin
                m0[0]  = ($urandom_range(0, 9) == 0);
                fc0[0] = ($urandom_range(0, 3) == 0);
                nf0[0] = $urandom_range(0, 1) == 1;
                for (int c = 0; c < 2; c++) begin
                    m1[c]  = ($urandom_range(0, 9) == 0);
                    fc1[c] = ($urandom_range(0, 3) == 0);
                    nf1[c] = $urandom_range(0, 1) == 1;
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
